// File: rtl/config_loader.sv
// Streams host words MSB-first into the fabric configuration chain, then recirculates the chain once and CRC-checks it.
// Each chain bit takes two clk cycles; an empty word buffer stalls the slot at config_clk=0 and raises wr_ready.
module config_loader #(
    parameter int CONFIG_WIDTH = 4651,
    parameter int WORD_WIDTH   = 32,
    parameter int CNT_WIDTH    = $clog2(CONFIG_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  sys_reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [WORD_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic                  config_out,
    output logic                  config_in,
    output logic                  config_clk,
    output logic                  config_en,
    output logic                  fabric_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [CNT_WIDTH-1:0]  bit_count
);
    localparam int NUM_WORDS = (CONFIG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int WC_W      = $clog2(NUM_WORDS + 1);
    localparam int BC_W      = $clog2(WORD_WIDTH + 1);
    localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(CONFIG_WIDTH - 1);
    localparam logic [15:0]          CRC_INIT = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_VERIFY, S_RELEASE, S_DONE, S_ERROR
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_config_in;
    logic                  r_config_clk;
    logic                  r_slot;
    logic [CNT_WIDTH-1:0]  r_bit_count;
    logic [15:0]           r_crc;
    logic [15:0]           r_exp_crc;
    logic [WORD_WIDTH-1:0] r_buf;
    logic [BC_W-1:0]       r_buf_cnt;
    logic [WC_W-1:0]       r_words;

    logic                  w_start_ok;
    logic                  w_shifting;
    logic                  w_slot_end;
    logic                  w_xfer;
    logic                  w_sample;
    logic [15:0]           w_crc_next;

    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic b);
        logic fb;
        fb = crc[15] ^ b;
        return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    assign w_start_ok = start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERROR);
    assign w_shifting = (r_state == S_LOAD) || (r_state == S_VERIFY);
    assign w_slot_end = w_shifting && r_config_clk && (r_bit_count == LAST_BIT);
    assign w_xfer     = wr_valid && wr_ready;
    // During VERIFY the CRC runs over what the chain tail presents, not what was sent.
    assign w_sample   = (r_state == S_VERIFY) ? config_out : r_config_in;
    assign w_crc_next = crc_step(r_crc, w_sample);

    assign wr_ready   = (r_state == S_LOAD) && (r_buf_cnt == '0) && (r_words < WC_W'(NUM_WORDS));
    assign config_in  = r_config_in;
    assign config_clk = r_config_clk;
    assign bit_count  = r_bit_count;

    always_ff @(posedge clk) begin
        if (sys_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) w_next = S_LOAD;
            end
            S_LOAD: begin
                if (abort)           w_next = S_ERROR;
                else if (w_slot_end) w_next = S_VERIFY;
            end
            S_VERIFY: begin
                if (abort)           w_next = S_ERROR;
                else if (w_slot_end) w_next = (r_crc == r_exp_crc) ? S_RELEASE : S_ERROR;
            end
            S_RELEASE: w_next = S_DONE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        config_en    = 1'b0;
        fabric_reset = 1'b1;
        busy         = 1'b0;
        done         = 1'b0;
        error        = 1'b0;
        case (r_state)
            S_LOAD, S_VERIFY: begin
                config_en = 1'b1;
                busy      = 1'b1;
            end
            S_RELEASE: busy = 1'b1;
            S_DONE: begin
                fabric_reset = 1'b0;
                done         = 1'b1;
            end
            S_ERROR: error = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sys_reset || w_start_ok) begin
            r_config_in  <= 1'b0;
            r_config_clk <= 1'b0;
            r_slot       <= 1'b0;
            r_bit_count  <= '0;
            r_crc        <= CRC_INIT;
            r_exp_crc    <= CRC_INIT;
            r_buf        <= '0;
            r_buf_cnt    <= '0;
            r_words      <= '0;
        end else begin
            if (w_xfer) begin
                r_buf     <= wr_data;
                r_buf_cnt <= BC_W'(WORD_WIDTH);
                r_words   <= r_words + 1'b1;
            end
            if (!w_shifting || abort) begin
                r_config_clk <= 1'b0;
                r_slot       <= 1'b0;
            end else if (r_config_clk) begin
                r_config_clk <= 1'b0;
                if (r_bit_count == LAST_BIT) begin
                    if (r_state == S_LOAD) begin
                        r_exp_crc   <= r_crc;
                        r_crc       <= CRC_INIT;
                        r_bit_count <= '0;
                        r_config_in <= config_out;
                        r_slot      <= 1'b1;
                    end else begin
                        r_bit_count <= r_bit_count + 1'b1;
                        r_config_in <= 1'b0;
                        r_slot      <= 1'b0;
                    end
                end else begin
                    r_bit_count <= r_bit_count + 1'b1;
                    if (r_state == S_VERIFY) begin
                        r_config_in <= config_out;
                    end else if (r_buf_cnt != '0) begin
                        r_config_in <= r_buf[WORD_WIDTH-1];
                        r_buf       <= {r_buf[WORD_WIDTH-2:0], 1'b0};
                        r_buf_cnt   <= r_buf_cnt - 1'b1;
                    end else begin
                        r_slot <= 1'b0;
                    end
                end
            end else if (r_slot) begin
                r_config_clk <= 1'b1;
                r_crc        <= w_crc_next;
            end else if (r_buf_cnt != '0) begin
                r_config_in <= r_buf[WORD_WIDTH-1];
                r_buf       <= {r_buf[WORD_WIDTH-2:0], 1'b0};
                r_buf_cnt   <= r_buf_cnt - 1'b1;
                r_slot      <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader: 40-bit fabric chain model, queued host words, directed scenarios plus randomized loads.
module tb_config_loader;
    localparam int CW    = 40;
    localparam int WW    = 16;
    localparam int CNT_W = $clog2(CW + 1);

    logic             clk = 1'b0;
    logic             sys_reset;
    logic             start;
    logic             abort;
    logic [WW-1:0]    wr_data;
    logic             wr_valid;
    logic             wr_ready;
    logic             config_out;
    logic             config_in;
    logic             config_clk;
    logic             config_en;
    logic             fabric_reset;
    logic             busy;
    logic             done;
    logic             error;
    logic [CNT_W-1:0] bit_count;

    logic [CW-1:0]    chain;
    logic [WW-1:0]    feed_q[$];
    int               gap_q[$];
    int               checks = 0;
    int               errors = 0;
    int               n_rises = 0;
    int               cycles = 0;

    assign config_out = chain[CW-1];

    always #5 clk = ~clk;

    config_loader #(.CONFIG_WIDTH(CW), .WORD_WIDTH(WW), .CNT_WIDTH(CNT_W)) dut (
        .clk(clk), .sys_reset(sys_reset), .start(start), .abort(abort),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .config_out(config_out), .config_in(config_in), .config_clk(config_clk),
        .config_en(config_en), .fabric_reset(fabric_reset), .busy(busy),
        .done(done), .error(error), .bit_count(bit_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected chain image: the first CW bits of the word stream, first bit at the tail.
    function automatic logic [CW-1:0] model_chain(input logic [WW-1:0] w0, w1, w2);
        logic [3*WW-1:0] s;
        s = {w0, w1, w2};
        return s[3*WW-1 -: CW];
    endfunction

    // One clk cycle: fabric shift register on config_clk rise, host word feeder, inputs driven at +1.
    task automatic step();
        logic xfer, cin, cclk;
        xfer = wr_valid && wr_ready;
        cin  = config_in;
        cclk = config_clk;
        @(posedge clk);
        #1;
        cycles++;
        if (config_clk && !cclk) begin
            chain = {chain[CW-2:0], cin};
            n_rises++;
        end
        if (xfer && feed_q.size() > 0) begin
            feed_q.delete(0);
            gap_q.delete(0);
        end
        wr_valid = 1'b0;
        if (feed_q.size() > 0) begin
            if (gap_q[0] > 0) gap_q[0] = gap_q[0] - 1;
            else begin
                wr_valid = 1'b1;
                wr_data  = feed_q[0];
            end
        end
    endtask

    task automatic push_word(input logic [WW-1:0] w, input int gap);
        feed_q.push_back(w);
        gap_q.push_back(gap);
    endtask

    task automatic flush();
        feed_q.delete();
        gap_q.delete();
        wr_valid = 1'b0;
    endtask

    task automatic start_load();
        n_rises = 0;
        cycles  = 0;
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    task automatic wait_rises(input int n, input string tag);
        int k = 0;
        while (n_rises < n && k < 1000) begin step(); k++; end
        chk(tag, 64'(n_rises), 64'(n));
    endtask

    task automatic wait_bc(input int v, input string tag);
        int k = 0;
        while (int'(bit_count) != v && k < 1000) begin step(); k++; end
        chk(tag, 64'(bit_count), 64'(v));
    endtask

    task automatic wait_end(input string tag);
        int k = 0;
        while (!(done || error) && k < 2000) begin step(); k++; end
        chk(tag, 64'(done || error), 64'd1);
    endtask

    task automatic chk_reset_vals(input string p);
        chk({p, "_cfg_in"},  64'(config_in),    64'd0);
        chk({p, "_cfg_clk"}, 64'(config_clk),   64'd0);
        chk({p, "_cfg_en"},  64'(config_en),    64'd0);
        chk({p, "_fab_rst"}, 64'(fabric_reset), 64'd1);
        chk({p, "_wr_rdy"},  64'(wr_ready),     64'd0);
        chk({p, "_busy"},    64'(busy),         64'd0);
        chk({p, "_done"},    64'(done),         64'd0);
        chk({p, "_error"},   64'(error),        64'd0);
        chk({p, "_bitcnt"},  64'(bit_count),    64'd0);
    endtask

    initial begin
        logic [WW-1:0]    w0, w1, w2;
        logic [CNT_W-1:0] prev;
        logic             ok;
        sys_reset = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        chain     = '0;
        repeat (3) step();
        chk_reset_vals("rst");
        sys_reset = 1'b0;
        step();

        // Nominal load with a continuous word stream.
        flush();
        push_word(16'hA5C3, 0); push_word(16'h0FF0, 0); push_word(16'h1234, 0);
        start_load();
        chk("a_busy", 64'(busy), 64'd1);
        chk("a_cfg_en", 64'(config_en), 64'd1);
        chk("a_fab_rst", 64'(fabric_reset), 64'd1);
        wait_rises(40, "a_load_rises");
        chk("a_chain_load", 64'(chain), 64'(40'hA5C30FF012));
        step();
        chk("a_verify_bc0", 64'(bit_count), 64'd0);
        chk("a_no_extra_rise", 64'(n_rises), 64'd40);
        wait_end("a_end");
        chk("a_done", 64'(done), 64'd1);
        chk("a_error", 64'(error), 64'd0);
        chk("a_fab_rst_low", 64'(fabric_reset), 64'd0);
        chk("a_busy_low", 64'(busy), 64'd0);
        chk("a_chain_kept", 64'(chain), 64'(40'hA5C30FF012));
        chk("a_total_rises", 64'(n_rises), 64'd80);
        chk("a_latency", 64'(cycles >= 160), 64'd1);

        // Host withholds the second word for 10 cycles after the first is consumed.
        flush();
        push_word(16'hA5C3, 0);
        start_load();
        wait_bc(16, "b_reach16");
        ok = 1'b1;
        repeat (10) begin
            step();
            if (config_clk !== 1'b0 || bit_count !== CNT_W'(16)) ok = 1'b0;
        end
        chk("b_gap_stall", 64'(ok), 64'd1);
        chk("b_gap_rdy", 64'(wr_ready), 64'd1);
        push_word(16'h0FF0, 0); push_word(16'h1234, 0);
        wait_rises(40, "b_load_rises");
        chk("b_chain_load", 64'(chain), 64'(40'hA5C30FF012));
        wait_end("b_end");
        chk("b_done", 64'(done), 64'd1);

        // Corrupt chain bit 5 early in VERIFY.
        flush();
        push_word(16'hA5C3, 0); push_word(16'h0FF0, 0); push_word(16'h1234, 0);
        start_load();
        wait_rises(40, "c_load_rises");
        wait_bc(2, "c_verify2");
        chain[5] = ~chain[5];
        wait_end("c_end");
        chk("c_error", 64'(error), 64'd1);
        chk("c_done", 64'(done), 64'd0);
        chk("c_fab_rst", 64'(fabric_reset), 64'd1);
        chk("c_cfg_en", 64'(config_en), 64'd0);

        // Abort mid-load, then recover with a fresh stream.
        flush();
        w0 = 16'($urandom); w1 = 16'($urandom); w2 = 16'($urandom);
        push_word(w0, 0); push_word(w1, 0); push_word(w2, 0);
        start_load();
        wait_bc(20, "d_reach20");
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("d_error", 64'(error), 64'd1);
        chk("d_cfg_clk", 64'(config_clk), 64'd0);
        chk("d_cfg_en", 64'(config_en), 64'd0);
        chk("d_busy", 64'(busy), 64'd0);
        flush();
        w0 = 16'($urandom); w1 = 16'($urandom); w2 = 16'($urandom);
        push_word(w0, 0); push_word(w1, 0); push_word(w2, 0);
        start_load();
        chk("d_error_clr", 64'(error), 64'd0);
        wait_end("d_end");
        chk("d_done", 64'(done), 64'd1);
        chk("d_chain", 64'(chain), 64'(model_chain(w0, w1, w2)));

        // Reset in the middle of VERIFY.
        flush();
        push_word(16'hFACE, 0); push_word(16'h0123, 0); push_word(16'h4567, 0);
        start_load();
        wait_rises(40, "e_load_rises");
        wait_bc(7, "e_verify7");
        sys_reset = 1'b1;
        step();
        sys_reset = 1'b0;
        chk_reset_vals("e");
        flush();
        w0 = 16'($urandom); w1 = 16'($urandom); w2 = 16'($urandom);
        push_word(w0, 0); push_word(w1, 0); push_word(w2, 0);
        start_load();
        wait_end("e_end");
        chk("e_done", 64'(done), 64'd1);
        chk("e_chain", 64'(chain), 64'(model_chain(w0, w1, w2)));

        // start while busy is ignored.
        flush();
        w0 = 16'($urandom); w1 = 16'($urandom); w2 = 16'($urandom);
        push_word(w0, 0); push_word(w1, 0); push_word(w2, 0);
        start_load();
        wait_bc(10, "f_reach10");
        prev  = bit_count;
        ok    = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        if (bit_count < prev) ok = 1'b0;
        prev = bit_count;
        while (n_rises < 40 && cycles < 1000) begin
            step();
            if (bit_count < prev) ok = 1'b0;
            prev = bit_count;
        end
        chk("f_monotonic", 64'(ok), 64'd1);
        chk("f_load_rises", 64'(n_rises), 64'd40);
        wait_end("f_end");
        chk("f_done", 64'(done), 64'd1);
        chk("f_chain", 64'(chain), 64'(model_chain(w0, w1, w2)));

        // Randomized words and host gaps.
        for (int it = 0; it < 5; it++) begin
            flush();
            w0 = 16'($urandom); w1 = 16'($urandom); w2 = 16'($urandom);
            push_word(w0, int'($urandom_range(0, 40)));
            push_word(w1, int'($urandom_range(0, 40)));
            push_word(w2, int'($urandom_range(0, 40)));
            start_load();
            wait_end($sformatf("r%0d_end", it));
            chk($sformatf("r%0d_done", it), 64'(done), 64'd1);
            chk($sformatf("r%0d_error", it), 64'(error), 64'd0);
            chk($sformatf("r%0d_chain", it), 64'(chain), 64'(model_chain(w0, w1, w2)));
            chk($sformatf("r%0d_rises", it), 64'(n_rises), 64'd80);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 SHALL have parameter CONFIG_WIDTH, default 4651, total bits in the fabric configuration chain.
REQ-002 SHALL have parameter WORD_WIDTH, default 32, width of host bitstream words.
REQ-003 SHALL have parameter CNT_WIDTH, default $clog2(CONFIG_WIDTH+1), width of the bit counter.
REQ-004 clk  input  1  single system clock; all logic on the rising edge.
REQ-005 sys_reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERROR.
REQ-007 abort  input  1  level; forces the ERROR state from LOAD or VERIFY.
REQ-008 wr_data  input  WORD_WIDTH  bitstream word, consumed MSB first.
REQ-009 wr_valid / wr_ready  input / output  1 / 1  word handshake; a transfer occurs when both are high on a clk edge.
REQ-010 config_out  input  1  serial tail of the fabric configuration chain.
REQ-011 config_in  output  1  serial data into the chain.
REQ-012 config_clk  output  1  registered configuration shift clock, generated in the clk domain.
REQ-013 config_en  output  1  chain shift enable.
REQ-014 fabric_reset  output  1  drives the fabric sys_reset.
REQ-015 busy, done, error  output  1 each  status flags.
REQ-016 bit_count  output  CNT_WIDTH  number of bits shifted in the current phase.

Function
REQ-017 States: IDLE, LOAD, VERIFY, RELEASE, DONE, ERROR; one-hot or binary encoding is permitted.
REQ-018 Bit slot: each chain bit occupies 2 clk cycles.
- Phase 0: config_clk=0; config_in updates.
- Phase 1: config_clk=1; the fabric samples on this rising edge.
- config_clk SHALL be 0 in every state other than an active slot.
REQ-019 IDLE to LOAD on start. Entering LOAD: bit_count=0, CRC=16'hFFFF, config_en=1, fabric_reset=1, busy=1.
REQ-020 LOAD word buffer:
- wr_ready=1 only when the buffer is empty and fewer than ceil(CONFIG_WIDTH/WORD_WIDTH) words have been accepted.
- wr_ready is 0 in all other states.
REQ-021 LOAD stall: when the buffer is empty at a phase-0 boundary, the slot stalls with config_clk held at 0 and no bit counted; it resumes on the cycle after a transfer.
REQ-022 LOAD bit tracking: each sent bit increments bit_count and updates the CRC.
- CRC is CRC-16-CCITT, bit-serial: fb=crc[15]^bit; crc={crc[14:0],1'b0}^(fb?16'h1021:0).
- Bits of the last word beyond CONFIG_WIDTH SHALL be discarded.
REQ-023 LOAD to VERIFY after bit CONFIG_WIDTH's phase 1.
- Entering VERIFY: store the CRC as expected_crc, reset the CRC to 16'hFFFF, set bit_count=0.
REQ-024 VERIFY: shift CONFIG_WIDTH slots with config_in=config_out (recirculation, so the chain contents are preserved).
- config_out is sampled in phase 0, before the edge; the CRC is computed over these samples.
REQ-025 VERIFY exit after CONFIG_WIDTH slots:
- CRC equals expected_crc: go to RELEASE.
- Otherwise: go to ERROR.
REQ-026 RELEASE: config_en=0 and fabric_reset=1 for exactly 1 cycle, then DONE.
REQ-027 DONE: fabric_reset=0, done=1, busy=0; stays until start or sys_reset.
REQ-028 ERROR: error=1, fabric_reset=1, config_en=0, busy=0; stays until start or sys_reset.
REQ-029 Abort: abort in LOAD or VERIFY goes to ERROR next cycle; a bit in progress is abandoned with config_clk=0.
REQ-030 Simultaneous events: abort has priority over slot completion; start is ignored while busy=1.
REQ-031 start in DONE or ERROR clears done/error and enters LOAD per REQ-019.
REQ-032 bit_count SHALL never exceed CONFIG_WIDTH.

Reset
REQ-033 sys_reset high at a clk edge SHALL force IDLE in any state, including mid-slot.
REQ-034 Reset values: config_in=0, config_clk=0, config_en=0, fabric_reset=1, wr_ready=0, busy=0, done=0, error=0, bit_count=0, word buffer empty, CRC=16'hFFFF.

Verification
REQ-035 CONFIG_WIDTH=40, WORD_WIDTH=16, fabric model is a 40-bit shift register, words 16'hA5C3, 16'h0FF0, 16'h1234 with no stalls -> 40 config_clk rising edges in LOAD, 8 LSBs of 16'h1234 dropped, chain holds A5C30FF012 after LOAD, done=1 and fabric_reset=0 after about 160+ cycles.
REQ-036 Same setup, wr_valid low for 10 cycles after the first word -> config_clk held at 0 during the gap, bit_count frozen at 16, final chain contents identical to REQ-035.
REQ-037 Same setup, fabric model flips chain bit 5 during VERIFY -> error=1, done=0, fabric_reset stays 1.
REQ-038 abort asserted at bit_count=20 in LOAD -> ERROR on the next cycle, config_clk=0, config_en=0; then start plus a full word stream -> done=1.
REQ-039 sys_reset pulsed during VERIFY at bit_count=7 -> the next cycle shows all REQ-034 values; a subsequent start completes a normal load.
REQ-040 start pulsed during LOAD -> ignored; bit_count continues monotonically and the load completes normally.
